// File: rtl/lpc_stream_pkg.sv
// Shared defaults, FSM state encoding and FIFO entry layout for the LPC stream sink.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lpc_stream_pkg;

  localparam int LPC_DATA_W     = 16;
  localparam int LPC_FRAME_LEN  = 160;
  localparam int LPC_FIFO_DEPTH = 16;

  // PASS stores words; DROP discards the rest of a frame that lost a word.
  typedef enum logic {
    PASS = 1'b0,
    DROP = 1'b1
  } lpc_state_e;

  // One buffered word with its frame markers, MSB first.
  typedef struct packed {
    logic                  sof;
    logic                  eof;
    logic [LPC_DATA_W-1:0] data;
  } lpc_entry_t;

endpackage

// File: rtl/lpc_stream_sink_if.sv
// Stream bundle between the LPC word source, the sink and its downstream consumer.
// Latency: n/a (wires only).
// Backpressure: input side has none; output side uses out_valid/out_ready.
interface lpc_stream_sink_if
  import lpc_stream_pkg::*;
#(
  parameter int DATA_W = LPC_DATA_W
);
  logic [DATA_W-1:0] in_d;
  logic              in_v;
  logic [DATA_W-1:0] out_data;
  logic              out_sof;
  logic              out_eof;
  logic              out_valid;
  logic              out_ready;

  // Environment side: produces words and accepts buffered output.
  modport master (
    output in_d, in_v, out_ready,
    input  out_data, out_sof, out_eof, out_valid
  );

  // Sink side.
  modport slave (
    input  in_d, in_v, out_ready,
    output out_data, out_sof, out_eof, out_valid
  );
endinterface

// File: rtl/lpc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// Latency: a word pushed at edge N is visible on pop_data from edge N.
// Backpressure: push ignored while full (full sampled before the edge); pop ignored while empty.
module lpc_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign fill     = count;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  // Zero the head while empty so stale storage never reaches the outputs.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage array needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lpc_stream_sink.sv
// Buffers an unthrottled LPC word stream, tags frame start/end and drops whole frame tails on overflow.
// Latency: one cycle from in_v to out_valid when the buffer is empty.
// Backpressure: out_ready stalls the output only; the input cannot be stalled, so words are lost when full.
module lpc_stream_sink
  import lpc_stream_pkg::*;
#(
  parameter int DATA_W     = LPC_DATA_W,
  parameter int FIFO_DEPTH = LPC_FIFO_DEPTH,
  parameter int FRAME_LEN  = LPC_FRAME_LEN
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  lpc_stream_sink_if.slave              st,
  input  logic                          clr_stat,
  output logic                          stat_overflow,
  output logic [7:0]                    stat_drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   stat_fill
);
  localparam int              POS_W    = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);
  localparam int              ENTRY_W  = DATA_W + 2;

  lpc_state_e         state;
  lpc_state_e         state_next;
  logic [POS_W-1:0]   pos;
  logic               pos_last;
  logic               full;
  logic               empty;
  logic               store;
  logic               drop_evt;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign pos_last = (pos == POS_LAST);

  // Frame position follows every presented word, stored or discarded, so resync lands on a real frame start.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  pos <= '0;
    else if (st.in_v)    pos <= pos_last ? '0 : pos + 1'b1;
  end

  // Admission state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= PASS;
    else                state <= state_next;
  end

  // Admission decision: store, or discard and count; a loss on the last word needs no resync.
  always_comb begin
    state_next = state;
    store      = 1'b0;
    drop_evt   = 1'b0;
    case (state)
      PASS: begin
        if (st.in_v) begin
          if (!full) begin
            store = 1'b1;
          end else begin
            drop_evt = 1'b1;
            if (!pos_last) state_next = DROP;
          end
        end
      end
      DROP: begin
        if (st.in_v && pos_last) state_next = PASS;
      end
      default: state_next = PASS;
    endcase
  end

  assign wr_entry = {pos == '0, pos_last, st.in_d};

  lpc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (store),
    .push_data (wr_entry),
    .full      (full),
    .pop       (st.out_ready),
    .pop_data  (rd_entry),
    .empty     (empty),
    .fill      (stat_fill)
  );

  // Output side runs independently of the admission state.
  assign st.out_valid = !empty;
  assign {st.out_sof, st.out_eof, st.out_data} = rd_entry;

  // Statistics: a loss in the same cycle as a clear survives the clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stat_overflow <= 1'b0;
      stat_drop_cnt <= '0;
    end else if (clr_stat) begin
      stat_overflow <= drop_evt;
      stat_drop_cnt <= {7'd0, drop_evt};
    end else if (drop_evt) begin
      stat_overflow <= 1'b1;
      if (stat_drop_cnt != 8'hFF) stat_drop_cnt <= stat_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lpc_stream_sink.sv
// Self-checking bench for lpc_stream_sink with FRAME_LEN=4, FIFO_DEPTH=4.
// Latency: checks outputs on the falling edge after each rising edge.
// Backpressure: drives out_ready from tables, sequences and random draws.
module tb_lpc_stream_sink;
  import lpc_stream_pkg::*;

  localparam int DW    = 16;
  localparam int FL    = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       clr_stat;
  logic       stat_overflow;
  logic [7:0] stat_drop_cnt;
  logic [2:0] stat_fill;

  lpc_stream_sink_if #(.DATA_W(DW)) bus ();

  lpc_stream_sink #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .FRAME_LEN  (FL)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .st            (bus),
    .clr_stat      (clr_stat),
    .stat_overflow (stat_overflow),
    .stat_drop_cnt (stat_drop_cnt),
    .stat_fill     (stat_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of stored entries plus frame position and discard flag.
  lpc_entry_t mq[$];
  int         m_pos;
  bit         m_drop;
  bit         m_ov;
  int         m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pos  = 0;
    m_drop = 0;
    m_ov   = 0;
    m_cnt  = 0;
  endtask

  // Effect of one rising edge given the inputs held during the preceding cycle.
  task automatic model_step(input bit v, input logic [15:0] d, input bit r, input bit c);
    bit         was_full;
    bit         lost;
    lpc_entry_t e;
    was_full = (mq.size() == DEPTH);
    lost     = 0;
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (v) begin
      if (!m_drop) begin
        if (!was_full) begin
          e.sof  = (m_pos == 0);
          e.eof  = (m_pos == FL - 1);
          e.data = d;
          mq.push_back(e);
        end else begin
          lost = 1;
          if (m_pos != FL - 1) m_drop = 1;
        end
      end else if (m_pos == FL - 1) begin
        m_drop = 0;
      end
      m_pos = (m_pos + 1) % FL;
    end
    if (c) begin
      m_ov  = lost;
      m_cnt = lost ? 1 : 0;
    end else if (lost) begin
      m_ov = 1;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic check_model();
    lpc_entry_t e;
    e = '0;
    if (mq.size() > 0) e = mq[0];
    chk("valid", bus.out_valid, (mq.size() > 0) ? 1 : 0);
    chk("data",  bus.out_data, e.data);
    chk("sof",   bus.out_sof,  e.sof);
    chk("eof",   bus.out_eof,  e.eof);
    chk("fill",  stat_fill, mq.size());
    chk("ovf",   stat_overflow, m_ov);
    chk("drops", stat_drop_cnt, m_cnt);
  endtask

  // Called on a falling edge; drives one cycle, advances the model, checks on the next falling edge.
  task automatic cycle(input bit v, input logic [15:0] d, input bit r, input bit c);
    bus.in_v      = v;
    bus.in_d      = d;
    bus.out_ready = r;
    clr_stat      = c;
    model_step(v, d, r, c);
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    bus.in_v      = 1'b0;
    bus.in_d      = '0;
    bus.out_ready = 1'b0;
    clr_stat      = 1'b0;
  endtask

  task automatic plain_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_model();
  endtask

  // Asserts reset between edges, checks outputs clear at once, releases with a word already valid.
  task automatic async_reset_release(input logic [15:0] d);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data",  bus.out_data, 0);
    chk("rst_sof",   bus.out_sof, 0);
    chk("rst_eof",   bus.out_eof, 0);
    chk("rst_fill",  stat_fill, 0);
    chk("rst_ovf",   stat_overflow, 0);
    chk("rst_drops", stat_drop_cnt, 0);
    model_reset();
    bus.in_v      = 1'b1;
    bus.in_d      = 16'hAAAA;
    bus.out_ready = 1'b0;
    clr_stat      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.in_d = d;
    rst_n    = 1'b1;
    model_step(1, d, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check_model();
    chk("rel_sof",  bus.out_sof, 1);
    chk("rel_data", bus.out_data, d);
  endtask

  typedef struct {
    bit          v;
    logic [15:0] d;
    bit          r;
    bit          c;
    bit          e_valid;
    logic [15:0] e_data;
    bit          e_sof;
    bit          e_eof;
    int          e_fill;
    bit          e_ovf;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Eight back-to-back words through an always-ready consumer, then one idle cycle.
    //          v  d        r  c  valid data     sof eof fill ovf
    tbl[0] = '{1, 16'h0001, 1, 0, 1, 16'h0001, 1, 0, 1, 0};
    tbl[1] = '{1, 16'h0002, 1, 0, 1, 16'h0002, 0, 0, 1, 0};
    tbl[2] = '{1, 16'h0003, 1, 0, 1, 16'h0003, 0, 0, 1, 0};
    tbl[3] = '{1, 16'h0004, 1, 0, 1, 16'h0004, 0, 1, 1, 0};
    tbl[4] = '{1, 16'h0005, 1, 0, 1, 16'h0005, 1, 0, 1, 0};
    tbl[5] = '{1, 16'h0006, 1, 0, 1, 16'h0006, 0, 0, 1, 0};
    tbl[6] = '{1, 16'h0007, 1, 0, 1, 16'h0007, 0, 0, 1, 0};
    tbl[7] = '{1, 16'h0008, 1, 0, 1, 16'h0008, 0, 1, 1, 0};
    tbl[8] = '{0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 0};

    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_model();

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_data", i),  bus.out_data,  tbl[i].e_data);
      chk($sformatf("tbl%0d_sof", i),   bus.out_sof,   tbl[i].e_sof);
      chk($sformatf("tbl%0d_eof", i),   bus.out_eof,   tbl[i].e_eof);
      chk($sformatf("tbl%0d_fill", i),  stat_fill,     tbl[i].e_fill);
      chk($sformatf("tbl%0d_ovf", i),   stat_overflow, tbl[i].e_ovf);
    end

    // Stalled consumer: four stored, frame start lost, rest of that frame discarded.
    plain_reset();
    for (int i = 0; i < 6; i++) cycle(1, 16'h0010 + 16'(i), 0, 0);
    chk("stall_fill",  stat_fill, 4);
    chk("stall_drops", stat_drop_cnt, 1);
    chk("stall_ovf",   stat_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_data", i), bus.out_data, 16'h0010 + 16'(i));
      cycle(0, 16'h0000, 1, 0);
    end
    cycle(1, 16'h0016, 1, 0);
    chk("drop_state_pos2", stat_fill, 0);
    cycle(1, 16'h0017, 1, 0);
    chk("drop_state_pos3", stat_fill, 0);
    cycle(1, 16'h0018, 1, 0);
    chk("resync_valid", bus.out_valid, 1);
    chk("resync_sof",   bus.out_sof, 1);
    chk("resync_data",  bus.out_data, 16'h0018);

    // Loss on the last word of a frame keeps the sink admitting the next frame.
    plain_reset();
    for (int i = 0; i < 4; i++) cycle(1, 16'h0020 + 16'(i), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 16'h0000, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 16'h0024 + 16'(i), 0, 0);
    chk("pre_last_fill", stat_fill, 4);
    cycle(1, 16'h0027, 0, 0);
    chk("last_drops", stat_drop_cnt, 1);
    chk("last_fill",  stat_fill, 4);
    for (int i = 0; i < 4; i++) cycle(0, 16'h0000, 1, 0);
    cycle(1, 16'h0028, 1, 0);
    chk("next_fill", stat_fill, 1);
    chk("next_sof",  bus.out_sof, 1);
    chk("next_data", bus.out_data, 16'h0028);

    // Clear coinciding with a loss, plain clear, then counter saturation.
    plain_reset();
    for (int i = 0; i < 4; i++) cycle(1, 16'h0030 + 16'(i), 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 16'h0040 + 16'(i), 0, 0);
    chk("five_drops", stat_drop_cnt, 5);
    cycle(1, 16'h0060, 0, 1);
    chk("clr_evt_drops", stat_drop_cnt, 1);
    chk("clr_evt_ovf",   stat_overflow, 1);
    cycle(0, 16'h0000, 0, 1);
    chk("clr_drops", stat_drop_cnt, 0);
    chk("clr_ovf",   stat_overflow, 0);
    for (int i = 0; i < 1100; i++) cycle(1, 16'(i), 0, 0);
    chk("sat_drops", stat_drop_cnt, 255);
    async_reset_release(16'h0077);

    // Reset mid-frame with three words buffered.
    plain_reset();
    for (int i = 0; i < 4; i++) cycle(1, 16'h0030 + 16'(i), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 16'h0000, 1, 0);
    cycle(1, 16'h0034, 0, 0);
    cycle(1, 16'h0035, 0, 0);
    chk("mid_fill", stat_fill, 3);
    async_reset_release(16'h0036);

    // Consumer ready every other cycle against a continuous source.
    plain_reset();
    for (int i = 0; i < 16; i++) cycle(1, 16'h0100 + 16'(i), (i % 2) == 1, 0);
    for (int i = 0; i < 6; i++) cycle(0, 16'h0000, 1, 0);

    // Random traffic against the model.
    plain_reset();
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 39) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
